// File: rtl/serial_pkg.sv
// Shared constants for the serial link: the parallel-to-serial and
// serial-to-parallel converters agree on the default word width here.
package serial_pkg;

    // Default parallel word width carried over the serial link.
    localparam int SERIAL_WORD_W = 8;

endpackage : serial_pkg

// File: rtl/s2p_word_fifo.sv
// word_fifo: small synchronous FIFO holding assembled words.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. Storage is not reset; only the
// pointers are, so an empty FIFO never exposes stale entries.
module word_fifo
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

    // Advance write/read pointers; push and pop together keep occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Word storage, written at the write pointer; no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wr_data;
    end

endmodule : word_fifo

// File: rtl/s2p.sv
// s2p: serial-to-parallel converter. Bits arrive LSB-first, are shifted
// into an N-bit register, and each completed word is pushed into a
// DEPTH-entry word FIFO that drives the parallel output.
//
// Handshake: on both sides a transfer happens in exactly the cycles where
// valid && ready are high at the rising clock edge. A valid source holds
// its data stable until the transfer; ready may change freely. s_ready is
// derived from registered state only, never from p_ready, so a pop frees
// space starting in the following cycle.
module s2p
    import serial_pkg::*;
#(
    parameter int N     = SERIAL_WORD_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    input  logic         s_data,
    output logic         s_ready,
    output logic         p_valid,
    output logic [N-1:0] p_data,
    input  logic         p_ready
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt;
    logic [N-1:0]  sr;
    logic [N-1:0]  word;
    logic          s_acc;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    // Only the final bit of a word needs a free FIFO slot; earlier bits
    // go into the shift register regardless.
    assign s_ready = !(fifo_full && (cnt == CNT_LAST));
    assign s_acc   = s_valid && s_ready;
    assign push    = s_acc && (cnt == CNT_LAST);
    assign pop     = p_valid && p_ready;
    assign p_valid = !fifo_empty;

    // Right shift: after N accepted bits the first bit sits at bit 0.
    assign word = {s_data, sr[N-1:1]};

    // Bit position counter, wrapping after the last bit of a word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (push) begin
            cnt <= '0;
        end else if (s_acc) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Shift register collecting the partial word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr <= '0;
        end else if (s_acc) begin
            sr <= word;
        end
    end

    word_fifo #(
        .WIDTH (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push    (push),
        .wr_data (word),
        .pop     (pop),
        .rd_data (p_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule : s2p
